fetch_stage: RTL

Instruction-fetch stage of the MIPS-32 pipeline. It holds the program counter and selects the next PC through a 4:1 next-PC mux steered by the 2-bit `pc_src` select. It issues fetch requests to instruction memory and captures each returned instruction in the IF/ID pipeline register for decode. It is the producer of the select and data inputs of the next-PC 4:1 mux and the consumer of that mux's output.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/fetch_stage_next_pc_mux.sv | 26 ++
 rtl/fetch_stage.sv | 106 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-32 pipeline.
// Covers the next-PC select encodings, the fetch FSM state type and the word width.
package mips_pkg;

  localparam int WORD_W = 32;

  // Next-PC mux select encodings
  typedef enum logic [1:0] {
    PC_SRC_SEQ = 2'd0,
    PC_SRC_BR  = 2'd1,
    PC_SRC_J   = 2'd2,
    PC_SRC_JR  = 2'd3
  } pc_src_t;

  // Fetch FSM states
  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HOLD  = 2'd2
  } fetch_state_t;

  // Turns a signed 16-bit word offset into a 32-bit byte offset.
  function automatic logic [WORD_W-1:0] sext_word_offset(input logic [15:0] off);
    return {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_next_pc_mux.sv
// 32-bit 4:1 next-PC mux.
// Pure selection; all target arithmetic is done by the caller.
module next_pc_mux
  import mips_pkg::*;
(
  input  logic [1:0]        sel,
  input  logic [WORD_W-1:0] seq_pc,
  input  logic [WORD_W-1:0] br_pc,
  input  logic [WORD_W-1:0] j_pc,
  input  logic [WORD_W-1:0] jr_pc,
  output logic [WORD_W-1:0] next_pc
);

  // Select one of the four candidate PCs
  always_comb begin
    next_pc = seq_pc;
    case (pc_src_t'(sel))
      PC_SRC_SEQ: next_pc = seq_pc;
      PC_SRC_BR:  next_pc = br_pc;
      PC_SRC_J:   next_pc = j_pc;
      PC_SRC_JR:  next_pc = jr_pc;
      default:    next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS-32 instruction-fetch stage.
// Holds the PC, issues fetches, and captures returned words into IF/ID.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        pc_src,
  input  logic [15:0]       branch_offset,
  input  logic [25:0]       jump_index,
  input  logic [WORD_W-1:0] jr_target,
  input  logic              stall,
  input  logic              flush,
  output logic [WORD_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic              imem_ready,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] if_instr,
  output logic [WORD_W-1:0] if_pc_plus4,
  output logic              if_valid
);

  fetch_state_t      state_reg;
  fetch_state_t      state_next;
  logic [WORD_W-1:0] pc_reg;
  logic [WORD_W-1:0] instr_reg;
  logic [WORD_W-1:0] pc4_reg;
  logic              valid_reg;

  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] br_target;
  logic [WORD_W-1:0] j_target;
  logic [WORD_W-1:0] jr_aligned;
  logic [WORD_W-1:0] next_pc;
  logic              capture;

  // Candidate targets; branch and jump are relative to the IF/ID PC+4
  assign pc_plus4   = pc_reg + 32'd4;
  assign br_target  = pc4_reg + sext_word_offset(branch_offset);
  assign j_target   = {pc4_reg[31:28], jump_index, 2'b00};
  assign jr_aligned = jr_target & 32'hFFFF_FFFC;

  next_pc_mux u_next_pc_mux (
    .sel     (pc_src),
    .seq_pc  (pc_plus4),
    .br_pc   (br_target),
    .j_pc    (j_target),
    .jr_pc   (jr_aligned),
    .next_pc (next_pc)
  );

  // A fetch completes only while requesting, not stalled, and memory is ready
  assign capture = (state_reg == FS_FETCH) && !stall && imem_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= FS_BOOT;
    else     state_reg <= state_next;
  end

  // FSM next-state logic; a flush always lands in FETCH
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = FS_FETCH;
    end else begin
      case (state_reg)
        FS_BOOT:  state_next = FS_FETCH;
        FS_FETCH: if (stall)  state_next = FS_HOLD;
        FS_HOLD:  if (!stall) state_next = FS_FETCH;
        default:  state_next = FS_BOOT;
      endcase
    end
  end

  // FSM outputs: request only while in FETCH
  always_comb begin
    imem_req = (state_reg == FS_FETCH);
  end

  // PC and IF/ID register: flush redirects, capture advances, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      instr_reg <= '0;
      pc4_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (flush) begin
      pc_reg    <= next_pc;
      valid_reg <= 1'b0;
    end else if (capture) begin
      instr_reg <= imem_rdata;
      pc4_reg   <= pc_plus4;
      valid_reg <= 1'b1;
      pc_reg    <= next_pc;
    end
  end

  assign imem_addr   = pc_reg;
  assign if_instr    = instr_reg;
  assign if_pc_plus4 = pc4_reg;
  assign if_valid    = valid_reg;

endmodule
